// File: rtl/full_adder_if.sv
// Operand/result bundle for the ripple-carry adder.
// The slave side is the adder; the master side drives operands and observes results.
interface full_adder_if #(
    parameter int unsigned WIDTH = 1
) ();
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             valid_i;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;
    logic [WIDTH-1:0] sum_q_o;
    logic             cout_q_o;
    logic             ovf_q_o;
    logic             valid_o;

    modport master (
        output a_i, b_i, cin_i, valid_i,
        input  sum_o, cout_o, ovf_o, sum_q_o, cout_q_o, ovf_q_o, valid_o
    );

    modport slave (
        input  a_i, b_i, cin_i, valid_i,
        output sum_o, cout_o, ovf_o, sum_q_o, cout_q_o, ovf_q_o, valid_o
    );
endinterface

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder built from 1-bit full-adder cells, with a
// combinational result path and a valid-qualified one-cycle registered copy.
module full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    full_adder_if.slave  bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             ovf;

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out of the MSB.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = bus.cin_i;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = bus.a_i[i] ^ bus.b_i[i] ^ carry[i];
            carry[i+1] = (bus.a_i[i] & bus.b_i[i]) |
                         (bus.a_i[i] & carry[i])   |
                         (bus.b_i[i] & carry[i]);
        end
        ovf = carry[WIDTH] ^ carry[WIDTH-1];
    end

    assign bus.sum_o  = sum;
    assign bus.cout_o = carry[WIDTH];
    assign bus.ovf_o  = ovf;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    // Results hold while valid_i is low; only the valid flag tracks every edge.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = bus.valid_i;
        if (bus.valid_i) begin
            sum_d  = sum;
            cout_d = carry[WIDTH];
            ovf_d  = ovf;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sum_q_o  = sum_q;
    assign bus.cout_q_o = cout_q;
    assign bus.ovf_q_o  = ovf_q;
    assign bus.valid_o  = valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 8 and 16 against an arithmetic
// reference model (unsigned sum and signed range check).
module tb_full_adder;

    logic clk;
    logic rst_ni;

    full_adder_if #(.WIDTH(1))  bus1  ();
    full_adder_if #(.WIDTH(8))  bus8  ();
    full_adder_if #(.WIDTH(16)) bus16 ();

    full_adder #(.WIDTH(1))  u_add1  (.clk_i(clk), .rst_ni(rst_ni), .bus(bus1));
    full_adder #(.WIDTH(8))  u_add8  (.clk_i(clk), .rst_ni(rst_ni), .bus(bus8));
    full_adder #(.WIDTH(16)) u_add16 (.clk_i(clk), .rst_ni(rst_ni), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signed overflow: true when the two's-complement sum leaves the w-bit range.
    function automatic logic sovf(input int w, input longint a, input longint b,
                                  input longint c);
        longint half, sa, sb, s;
        half = longint'(1) << (w - 1);
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        s    = sa + sb + c;
        return (s < -half) || (s >= half);
    endfunction

    logic [7:0] da [4] = '{8'hFF, 8'h7F, 8'hFF, 8'hFF};
    logic [7:0] db [4] = '{8'h01, 8'h01, 8'hFF, 8'h00};
    logic       dc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [2:0]  v3;
        logic [15:0] ra, rb;
        logic        rc, rv;
        longint      full;
        logic [63:0] exp_sq;
        logic        exp_oq, exp_vq;

        bus1.a_i = '0;  bus1.b_i = '0;  bus1.cin_i = 1'b0;  bus1.valid_i = 1'b0;
        bus8.a_i = '0;  bus8.b_i = '0;  bus8.cin_i = 1'b0;  bus8.valid_i = 1'b0;
        bus16.a_i = '0; bus16.b_i = '0; bus16.cin_i = 1'b0; bus16.valid_i = 1'b0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #1;
        chk("rst1_sum_q", 64'(bus1.sum_q_o), 64'd0);
        chk("rst1_cout_q", 64'(bus1.cout_q_o), 64'd0);
        chk("rst1_ovf_q", 64'(bus1.ovf_q_o), 64'd0);
        chk("rst1_valid", 64'(bus1.valid_o), 64'd0);
        chk("rst8_sum_q", 64'(bus8.sum_q_o), 64'd0);
        chk("rst8_valid", 64'(bus8.valid_o), 64'd0);
        chk("rst16_sum_q", 64'(bus16.sum_q_o), 64'd0);
        chk("rst16_valid", 64'(bus16.valid_o), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // WIDTH=1 exhaustive
        for (int v = 0; v < 8; v++) begin
            v3 = 3'(v);
            bus1.a_i   = v3[2];
            bus1.b_i   = v3[1];
            bus1.cin_i = v3[0];
            #10;
            full = longint'(v3[2]) + longint'(v3[1]) + longint'(v3[0]);
            chk("w1_sum", 64'({bus1.cout_o, bus1.sum_o}), 64'(full));
            chk("w1_ovf", 64'(bus1.ovf_o),
                64'(sovf(1, longint'(v3[2]), longint'(v3[1]), longint'(v3[0]))));
        end

        // WIDTH=8 boundary vectors
        for (int i = 0; i < 4; i++) begin
            bus8.a_i   = da[i];
            bus8.b_i   = db[i];
            bus8.cin_i = dc[i];
            #1;
            full = longint'(da[i]) + longint'(db[i]) + longint'(dc[i]);
            chk("w8_sum", 64'({bus8.cout_o, bus8.sum_o}), 64'(full));
            chk("w8_ovf", 64'(bus8.ovf_o),
                64'(sovf(8, longint'(da[i]), longint'(db[i]), longint'(dc[i]))));
        end

        // Registered path
        @(negedge clk);
        bus8.a_i = 8'h12; bus8.b_i = 8'h34; bus8.cin_i = 1'b1; bus8.valid_i = 1'b1;
        @(posedge clk); #1;
        chk("reg_sum_q", 64'(bus8.sum_q_o), 64'h47);
        chk("reg_cout_q", 64'(bus8.cout_q_o), 64'd0);
        chk("reg_ovf_q", 64'(bus8.ovf_q_o), 64'd0);
        chk("reg_valid", 64'(bus8.valid_o), 64'd1);
        @(negedge clk);
        bus8.valid_i = 1'b0; bus8.a_i = 8'h55;
        @(posedge clk); #1;
        chk("hold_valid", 64'(bus8.valid_o), 64'd0);
        chk("hold_sum_q", 64'(bus8.sum_q_o), 64'h47);

        // Async reset between edges
        @(negedge clk);
        bus8.valid_i = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_valid", 64'(bus8.valid_o), 64'd1);
        chk("pre_rst_sum_q", 64'({bus8.ovf_q_o, bus8.cout_q_o, bus8.sum_q_o}), 64'h28A);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_sum_q", 64'(bus8.sum_q_o), 64'd0);
        chk("arst_cout_q", 64'(bus8.cout_q_o), 64'd0);
        chk("arst_ovf_q", 64'(bus8.ovf_q_o), 64'd0);
        chk("arst_valid", 64'(bus8.valid_o), 64'd0);
        bus8.a_i = 8'h01;
        #1;
        chk("arst_comb", 64'({bus8.cout_o, bus8.sum_o}), 64'h36);
        @(negedge clk);
        bus8.valid_i = 1'b0;
        rst_ni = 1'b1;

        // WIDTH=16 random with registered-path scoreboard
        exp_sq = '0; exp_oq = 1'b0; exp_vq = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            if (n % 97 == 0) begin
                ra = 16'hFFFF;
                rb = 16'hFFFF;
            end
            bus16.a_i = ra; bus16.b_i = rb; bus16.cin_i = rc; bus16.valid_i = rv;
            #1;
            full = longint'(ra) + longint'(rb) + longint'(rc);
            chk("r16_sum", 64'({bus16.cout_o, bus16.sum_o}), 64'(full));
            chk("r16_ovf", 64'(bus16.ovf_o),
                64'(sovf(16, longint'(ra), longint'(rb), longint'(rc))));
            if (rv) begin
                exp_sq = 64'(full);
                exp_oq = sovf(16, longint'(ra), longint'(rb), longint'(rc));
            end
            exp_vq = rv;
            @(posedge clk); #1;
            chk("r16_sum_q", 64'({bus16.cout_q_o, bus16.sum_q_o}), exp_sq);
            chk("r16_ovf_q", 64'(bus16.ovf_q_o), 64'(exp_oq));
            chk("r16_valid", 64'(bus16.valid_o), 64'(exp_vq));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
Parameterised binary adder built from single-bit full-adder cells in a ripple-carry chain. It provides a combinational sum/carry path and a one-cycle registered copy qualified by a valid strobe. With WIDTH=1 it is the classic 1-bit full adder used as a leaf cell in datapath arithmetic. Higher-level adders/ALUs instantiate it either as a pure combinational cell or as a pipelined stage.

Parameters:
WIDTH, 1, operand width in bits (legal range 1..64)

Ports:
clk_i  input  1  clock, rising-edge active
rst_ni  input  1  asynchronous active-low reset
a_i  input  WIDTH  operand A (unsigned/two's-complement agnostic)
b_i  input  WIDTH  operand B
cin_i  input  1  carry-in
valid_i  input  1  operands valid; captured into output register when high
sum_o  output  WIDTH  combinational sum, (a_i + b_i + cin_i) mod 2^WIDTH
cout_o  output  1  combinational carry-out of MSB
ovf_o  output  1  combinational signed overflow (carry into MSB XOR carry out of MSB)
sum_q_o  output  WIDTH  registered sum
cout_q_o  output  1  registered carry-out
ovf_q_o  output  1  registered signed overflow
valid_o  output  1  registered outputs valid

Behaviour:
- Bit cell i: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]); c[0] = cin_i.
- {cout_o, sum_o} = a_i + b_i + cin_i exactly, as a WIDTH+1-bit unsigned result; zero latency, no dependency on clk_i/rst_ni.
- ovf_o = c[WIDTH] ^ c[WIDTH-1]; for WIDTH=1, ovf_o = cout_o ^ cin_i.
- Combinational outputs settle within one propagation delay of any input change; no latches, no internal state on this path.
- Registered path, latency 1 cycle: on rising clk_i with valid_i=1, sum_q_o/cout_q_o/ovf_q_o load the combinational values and valid_o<=1.
- valid_i=0 at a rising edge: sum_q_o/cout_q_o/ovf_q_o hold previous values; valid_o<=0.
- Back-to-back valid_i=1 accepts one new result per cycle; no backpressure.
- rst_ni low (asynchronous, any time): sum_q_o=0, cout_q_o=0, ovf_q_o=0, valid_o=0 immediately; combinational outputs are unaffected by reset.
- Release of rst_ni is synchronised by the integrating design; first capture occurs at the first rising edge with rst_ni=1 and valid_i=1.
- Wrap-around: all-ones + all-ones + 1 gives sum = all-ones, cout=1. all-ones + 0 + 1 gives sum=0, cout=1.
- X on inputs is not masked; the outputs follow.

Test Plan:
- WIDTH=1 exhaustive: {a_i,b_i,cin_i} stepped 000..111, 10 ns each -> {cout_o,sum_o} = 00,01,01,10,01,10,10,11.
- WIDTH=1 ovf: a=1,b=1,cin=0 -> ovf_o=1; a=0,b=0,cin=1 -> ovf_o=1; a=1,b=0,cin=1 -> ovf_o=0.
- WIDTH=8: a=0xFF,b=0x01,cin=0 -> sum_o=0x00, cout_o=1, ovf_o=0; a=0x7F,b=0x01,cin=0 -> sum_o=0x80, cout_o=0, ovf_o=1.
- Registered path: valid_i=1 with a=0x12,b=0x34,cin=1 at edge N -> at edge N+1 sum_q_o=0x47, valid_o=1; valid_i=0 next cycle -> valid_o=0, sum_q_o holds 0x47.
- Async reset mid-stream: assert rst_ni=0 between edges while valid_o=1 -> sum_q_o/cout_q_o/ovf_q_o/valid_o go 0 without a clock edge; sum_o keeps tracking the inputs.
- Random WIDTH=16: 1000 random a/b/cin vectors -> {cout_o,sum_o} equals reference a+b+cin; registered outputs match one cycle later.
